// File: rtl/imul_generate_pkg.sv
// imul_generate_pkg: shared constants for the array multiplier
package imul_generate_pkg;
  localparam int DEFAULT_MUL_WIDTH = 16;
endpackage

// File: rtl/imul_adder_row.sv
// imul_adder_row: one ripple-carry row adding a partial product to the running upper sum
module imul_adder_row #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] pp,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH:0]   sum
);
  logic c [WIDTH+1];
  assign c[0] = 1'b0;
  for (genvar j = 0; j < WIDTH; j++) begin : g_fa
    assign sum[j]   = pp[j] ^ acc[j] ^ c[j];
    assign c[j+1]   = (pp[j] & acc[j]) | (c[j] & (pp[j] ^ acc[j]));
  end
  assign sum[WIDTH] = c[WIDTH];
endmodule

// File: rtl/imul_generate.sv
// imul_generate: unsigned array multiplier with a registered 2*WIDTH-bit product
module imul_generate
  import imul_generate_pkg::*;
#(
  parameter int WIDTH = DEFAULT_MUL_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 iValid,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   oResult,
  output logic                 oValid
);
  logic [WIDTH-1:0]   pp  [WIDTH];
  logic [WIDTH:0]     run [WIDTH];
  logic [2*WIDTH-1:0] prod;
  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    assign pp[i] = A & {WIDTH{B[i]}};
  end
  assign run[0] = {1'b0, pp[0]};
  for (genvar i = 1; i < WIDTH; i++) begin : g_row
    imul_adder_row #(.WIDTH(WIDTH)) u_row (
      .pp  (pp[i]),
      .acc (run[i-1][WIDTH:1]),
      .sum (run[i])
    );
    assign prod[i-1] = run[i-1][0];
  end
  assign prod[2*WIDTH-1:WIDTH-1] = run[WIDTH-1];
  // capture the product only for valid pairs; valid flag follows iValid every cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      oResult <= '0;
      oValid  <= 1'b0;
    end else begin
      oValid  <= iValid;
      oResult <= iValid ? prod : oResult;
    end
  end
endmodule

// File: tb/tb_imul_generate.sv
// tb_imul_generate: self-checking bench for imul_generate (vectors, corner sequences, random vs model)
module tb_imul_generate;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        iValid = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [31:0] oResult;
  logic        oValid;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];

  imul_generate #(.WIDTH(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .iValid  (iValid),
    .A       (A),
    .B       (B),
    .oResult (oResult),
    .oValid  (oValid)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic v);
    @(negedge clock);
    A = a;
    B = b;
    iValid = v;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] model_res;
    logic        model_val;
    logic [15:0] ra, rb;
    logic        rv;
    vecs[0] = '{16'h0000, 16'hBEEF, 32'h0000_0000};
    vecs[1] = '{16'h0001, 16'hBEEF, 32'h0000_BEEF};
    vecs[2] = '{16'hFFFF, 16'h0001, 32'h0000_FFFF};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[4] = '{16'h0003, 16'h0007, 32'd21};
    vecs[5] = '{16'h1234, 16'h0010, 32'h0001_2340};
    vecs[6] = '{16'h8000, 16'h0002, 32'h0001_0000};

    #1;
    check("reset_result", oResult, 32'h0);
    check("reset_valid", {31'b0, oValid}, 32'h0);
    tick();
    check("reset_hold_result", oResult, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    drive(16'd4, 16'd5, 1'b1);
    tick();
    check("basic_result", oResult, 32'd20);
    check("basic_valid", {31'b0, oValid}, 32'h1);
    while ($time < 100) @(negedge clock);
    check("basic_hold_100ns", oResult, 32'd20);

    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_result", oResult, 32'h0);
    check("async_reset_valid", {31'b0, oValid}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    iValid = 1'b0;
    tick();
    check("post_reset_valid0", {31'b0, oValid}, 32'h0);
    tick();
    check("post_reset_valid1", {31'b0, oValid}, 32'h0);
    check("post_reset_result", oResult, 32'h0);

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].a, vecs[i].b, 1'b1);
      tick();
      check($sformatf("vec%0d_result", i), oResult, vecs[i].exp);
      check($sformatf("vec%0d_valid", i), {31'b0, oValid}, 32'h1);
    end

    drive(16'h1111, 16'h2222, 1'b0);
    tick();
    check("gate_hold_result", oResult, 32'h0001_0000);
    check("gate_valid", {31'b0, oValid}, 32'h0);
    drive(16'h5555, 16'h7777, 1'b0);
    tick();
    check("gate_hold_result2", oResult, 32'h0001_0000);

    model_res = 32'h0001_0000;
    for (int i = 0; i < 400; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rv = ($urandom_range(0, 3) != 0);
      if (i % 50 == 0) begin
        ra = 16'hFFFF;
        rb = 16'($urandom_range(0, 1) ? 16'hFFFF : 16'h0000);
      end
      drive(ra, rb, rv);
      if (rv) model_res = 32'(ra) * 32'(rb);
      model_val = rv;
      tick();
      check($sformatf("rand%0d_result", i), oResult, model_res);
      check($sformatf("rand%0d_valid", i), {31'b0, oValid}, {31'b0, model_val});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
